// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t  : fetch FSM states (IDLE, READ, LATCH)
//   FETCH_DATA_W   : datapath / memory bus width
//   FETCH_RESET_PC : default PC value loaded on reset
package fetch_pkg;

  localparam int FETCH_DATA_W = 16;
  localparam logic [FETCH_DATA_W-1:0] FETCH_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/reg_16.sv
// reg_16: load-enable register with asynchronous active-high clear.
// Used for the MAR, MDR and IR of the fetch stage.
// Ports:
//   Clk   - rising-edge clock
//   Reset - async active-high clear (Q -> 0)
//   Load  - capture D on the next rising edge
//   D     - data in
//   Q     - registered data out
module reg_16
  import fetch_pkg::*;
#(
  parameter int W = FETCH_DATA_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Load,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Q <= '0;
    end else if (Load) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/ir_fetch_unit.sv
// ir_fetch_unit: instruction-fetch stage of the 16-bit datapath.
// Holds PC, MAR, MDR and IR and runs the read handshake to instruction memory.
//
// Memory handshake: mem_rd is high for every cycle the FSM is in READ and
// mem_addr (= MAR) is held stable for that whole time; a transfer happens on
// the rising edge where mem_rd and mem_rdy are both high. mem_rdy in any
// other state is ignored.
//
// Ports:
//   Clk, Reset     - clock, async active-high reset
//   fetch_go       - fetch the instruction at PC (sampled in IDLE only)
//   pc_ld, pc_in   - redirect PC (immediate in IDLE, deferred while busy)
//   mem_rdata      - instruction memory read data
//   mem_rdy        - read data valid this cycle
//   mem_addr       - memory address (MAR)
//   mem_rd         - memory read strobe
//   PC             - next-instruction address
//   fetch_pc       - address of the instruction currently in IR
//   IR, offset9    - instruction register and IR[8:0]
//   ir_valid       - one-cycle pulse when IR has just been updated
//   busy           - fetch in progress
//   state_dbg      - current FSM state (fetch_state_t encoding)
module ir_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_W = FETCH_DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              fetch_go,
  input  logic              pc_ld,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] fetch_pc,
  output logic [DATA_W-1:0] IR,
  output logic [8:0]        offset9,
  output logic              ir_valid,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  fetch_state_t      state;
  logic              pending_ld;
  logic [DATA_W-1:0] pend_pc;
  logic [DATA_W-1:0] pc_inc;
  logic [DATA_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic              fetch_start;
  logic              mar_ld;
  logic              mdr_ld;
  logic              ir_ld;

  // Natural wrap: 16'hFFFF + 1 = 16'h0000.
  assign pc_inc = PC + {{(DATA_W-1){1'b0}}, 1'b1};

  // A redirect in IDLE wins over a fetch request in the same cycle.
  assign fetch_start = (state == IDLE) && !pc_ld && fetch_go;
  assign mar_ld      = fetch_start;
  assign mdr_ld      = (state == READ) && mem_rdy;
  assign ir_ld       = (state == LATCH);

  reg_16 #(.W(DATA_W)) u_mar (
    .Clk   (Clk),
    .Reset (Reset),
    .Load  (mar_ld),
    .D     (PC),
    .Q     (mar_q)
  );

  reg_16 #(.W(DATA_W)) u_mdr (
    .Clk   (Clk),
    .Reset (Reset),
    .Load  (mdr_ld),
    .D     (mem_rdata),
    .Q     (mdr_q)
  );

  reg_16 #(.W(DATA_W)) u_ir (
    .Clk   (Clk),
    .Reset (Reset),
    .Load  (ir_ld),
    .D     (mdr_q),
    .Q     (IR)
  );

  // State decodes; they follow the async reset immediately because state does.
  assign mem_rd    = (state == READ);
  assign busy      = (state != IDLE);
  assign mem_addr  = mar_q;
  assign offset9   = IR[8:0];
  assign state_dbg = state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      PC         <= RESET_PC;
      fetch_pc   <= '0;
      pending_ld <= 1'b0;
      pend_pc    <= '0;
      ir_valid   <= 1'b0;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pc_ld) begin
            PC <= pc_in;
          end else if (fetch_go) begin
            fetch_pc <= PC;
            PC       <= pc_inc;
            state    <= READ;
          end
        end
        READ: begin
          // Redirects while busy are parked; the newest one wins.
          if (pc_ld) begin
            pending_ld <= 1'b1;
            pend_pc    <= pc_in;
          end
          if (mem_rdy) begin
            state <= LATCH;
          end
        end
        LATCH: begin
          ir_valid   <= 1'b1;
          pending_ld <= 1'b0;
          state      <= IDLE;
          // A redirect arriving on this very edge is the newest one.
          if (pc_ld) begin
            PC <= pc_in;
          end else if (pending_ld) begin
            PC <= pend_pc;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ir_fetch_unit.md
Name: ir_fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit datapath.
- Holds PC, MAR, MDR and IR, and runs the read handshake to instruction memory.
- Presents the fetched IR and IR[8:0] (offset9) to the downstream sign-extension and address-adder logic.
- Control unit requests fetches and may redirect PC for branches and jumps.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- DATA_W, 16, width of PC, MAR, MDR, IR and the memory bus.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- fetch_go  in  1  request: fetch the instruction at PC (sampled in IDLE only).
- pc_ld  in  1  redirect: load PC from pc_in.
- pc_in  in  DATA_W  redirect target (branch/JMP address from the address adder).
- mem_rdata  in  DATA_W  instruction memory read data.
- mem_rdy  in  1  memory read data valid this cycle.
- mem_addr  out  DATA_W  memory address (= MAR).
- mem_rd  out  1  memory read strobe.
- PC  out  DATA_W  next-instruction address.
- fetch_pc  out  DATA_W  address of the instruction currently in IR.
- IR  out  DATA_W  instruction register.
- offset9  out  9  IR[8:0], feeds the 9-bit sign extender.
- ir_valid  out  1  one-cycle pulse: IR just updated.
- busy  out  1  fetch in progress (state != IDLE).

Behaviour:
- Reset (async, any state):
  - state=IDLE; PC=RESET_PC; MAR=MDR=IR=fetch_pc=0; pending_ld=0; pend_pc=0.
  - ir_valid=0, mem_rd=0, busy=0; mem_addr=0.
  - Reset mid-fetch drops mem_rd combinationally and discards the fetch.
- States: IDLE, READ, LATCH.
- IDLE:
  - pc_ld=1: PC<=pc_in and stay IDLE. pc_ld has priority; fetch_go in the same cycle is ignored.
  - Else fetch_go=1: MAR<=PC, fetch_pc<=PC, PC<=PC+1 (mod 2^16; 16'hFFFF wraps to 16'h0000), go to READ.
- READ:
  - mem_rd=1, mem_addr=MAR, held stable until mem_rdy.
  - Edge with mem_rdy=1: MDR<=mem_rdata, go to LATCH.
  - mem_rdy=0: stay in READ indefinitely (no timeout).
- LATCH: mem_rd=0; on the next edge IR<=MDR, ir_valid<=1 for exactly one cycle, go to IDLE.
- Latency, fetch_go sampled at edge k with mem_rdy tied high:
  - READ during k+1, LATCH during k+2.
  - New IR and ir_valid=1 during k+3.
  - Back-to-back: fetch_go held high gives one instruction every 3 cycles.
- mem_rdy outside READ is ignored.
- Redirect while busy:
  - pc_ld in READ or LATCH sets pending_ld=1 and pend_pc<=pc_in; the last one wins.
  - On the LATCH->IDLE edge: PC<=pend_pc if pending_ld, else PC keeps the incremented value; pending_ld clears.
  - The instruction already in flight still completes.
- IR changes only on the LATCH->IDLE edge. offset9 always equals IR[8:0].
- All outputs are registered except mem_rd, busy and mem_addr, which decode state/MAR.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, READ, LATCH}.
  - localparam RESET_PC default.
  - DATA_W constant.
- Sub-module reg_16 (Clk, Reset, Load, D, Q): async-reset load-enable register, instantiated for MAR, MDR and IR.
- PC and the pending-redirect logic stay in the top module.

Test Plan:
- Reset, then fetch_go pulse at PC=0, mem_rdy=1, mem_rdata=16'h0E05:
  - mem_rd=1 with mem_addr=0 one cycle.
  - IR=16'h0E05, offset9=9'h005, ir_valid pulse 3 cycles after fetch_go.
  - PC=1, fetch_pc=0.
- fetch_go with mem_rdy low 4 cycles, then high with data 16'h1234:
  - mem_rd held 5 cycles at constant mem_addr; IR=16'h1234.
  - Exactly one ir_valid pulse.
- pc_ld=1, pc_in=16'h3000 in IDLE together with fetch_go:
  - PC=16'h3000, no fetch (busy stays 0).
  - Next fetch_go reads address 16'h3000.
- pc_ld=1, pc_in=16'h0040 during READ:
  - Current fetch completes.
  - After the ir_valid pulse PC=16'h0040 (not old PC+1).
- PC=16'hFFFF, fetch_go: mem_addr=16'hFFFF, PC becomes 16'h0000.
- Assert Reset in READ mid-stall:
  - mem_rd and busy drop immediately; PC=RESET_PC; IR=0.
  - No ir_valid pulse after release.
